// File: rtl/writeback_unit_pkg.sv
// Shared constants and result-select encodings for the writeback unit.
// Imported by writeback_unit and sb_counter.
package writeback_unit_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC2  = 2'b10,
    WB_RSVD = 2'b11
  } wbsel_e;

endpackage

// File: rtl/writeback_unit_sb_counter.sv
// Saturating pending-write counter for one scoreboard register.
// Ports: inc (+1), decCnt (0..2 decrements), cnt (value), err (over/underflow now).
module sb_counter #(
  parameter int CNT_W = writeback_unit_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [1:0]       decCnt,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic signed [CNT_W+1:0] MAXS =
    $signed({2'b00, {CNT_W{1'b1}}});

  logic signed [CNT_W+1:0] sum;
  logic [CNT_W-1:0]        cntNxt;

  // Net of all events this cycle, in a width that holds -2..max+1.
  always_comb begin
    sum = $signed({2'b00, cnt})
        + $signed({{(CNT_W+1){1'b0}}, inc})
        - $signed({{CNT_W{1'b0}}, decCnt});
    err    = 1'b0;
    cntNxt = sum[CNT_W-1:0];
    if (sum < 0) begin
      err    = 1'b1;
      cntNxt = '0;
    end else if (sum > MAXS) begin
      err    = 1'b1;
      cntNxt = {CNT_W{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cntNxt;
  end

endmodule

// File: rtl/writeback_unit.sv
// WB pipeline register, result mux and per-register pending-write scoreboard.
// Ports: MEM bundle in, issue/cancel events in, RF write out, two busy queries, sb_err.
module writeback_unit #(
  parameter int DATA_W = writeback_unit_pkg::DATA_W,
  parameter int NREGS  = writeback_unit_pkg::NREGS,
  parameter int CNT_W  = writeback_unit_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [3:0]        mem_dst,
  input  logic [1:0]        mem_wbsel,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus2,
  input  logic              iss_valid,
  input  logic              iss_regwrite,
  input  logic [3:0]        iss_dst,
  input  logic              can_valid,
  input  logic [3:0]        can_dst,
  input  logic [3:0]        q_src1,
  input  logic [3:0]        q_src2,
  output logic [3:0]        DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              sb_err
);

  import writeback_unit_pkg::*;

  logic              wbValid;
  logic              wbRegWrite;
  logic [3:0]        wbDst;
  wbsel_e            wbSel;
  logic [DATA_W-1:0] wbAlu;
  logic [DATA_W-1:0] wbLoad;
  logic [DATA_W-1:0] wbPc2;
  logic [DATA_W-1:0] wbData;
  logic              writeRaw;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbDst      <= '0;
      wbSel      <= WB_ALU;
      wbAlu      <= '0;
      wbLoad     <= '0;
      wbPc2      <= '0;
    end else begin
      wbValid    <= mem_valid & ~stall;
      wbRegWrite <= mem_regwrite;
      wbDst      <= mem_dst;
      wbSel      <= wbsel_e'(mem_wbsel);
      wbAlu      <= mem_alu_result;
      wbLoad     <= mem_load_data;
      wbPc2      <= mem_pc_plus2;
    end
  end

  always_comb begin
    wbData = '0;
    unique case (wbSel)
      WB_ALU:  wbData = wbAlu;
      WB_LOAD: wbData = wbLoad;
      WB_PC2:  wbData = wbPc2;
      WB_RSVD: wbData = '0;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign writeRaw = wbValid & wbRegWrite & (wbDst != '0);
  assign WriteReg = writeRaw & ~rst;
  assign DstReg   = rst ? '0 : wbDst;
  assign DstData  = rst ? '0 : wbData;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] errVec;

  // R0 is hardwired: no counter, never busy.
  assign cnt[0]    = '0;
  assign errVec[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_sb
    logic issHit;
    logic comHit;
    logic canHit;
    assign issHit = iss_valid & iss_regwrite & (iss_dst == 4'(i));
    assign comHit = WriteReg & (DstReg == 4'(i));
    assign canHit = can_valid & (can_dst == 4'(i));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (issHit),
      .decCnt ({1'b0, comHit} + {1'b0, canHit}),
      .cnt    (cnt[i]),
      .err    (errVec[i])
    );
  end

  // A last pending write committing this cycle is bypassed by the RF.
  always_comb begin
    q_busy1 = ~rst & (q_src1 != '0) & (cnt[q_src1] != '0)
            & ~((cnt[q_src1] == CNT_W'(1)) & WriteReg
                & (DstReg == q_src1));
    q_busy2 = ~rst & (q_src2 != '0) & (cnt[q_src2] != '0)
            & ~((cnt[q_src2] == CNT_W'(1)) & WriteReg
                & (DstReg == q_src2));
  end

  always_ff @(posedge clk) begin
    if (rst)          sb_err <= 1'b0;
    else if (|errVec) sb_err <= 1'b1;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 16, register data width.
- NREGS, 16, number of architectural registers (index width 4).
- CNT_W, 2, width of each scoreboard pending-write counter.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, reset; synchronous, active-high.
- stall, in, 1, MEM stage frozen; WB stage receives a bubble.
- mem_valid, in, 1, MEM stage holds a live instruction.
- mem_regwrite, in, 1, that instruction writes a register.
- mem_dst, in, 4, destination register index.
- mem_wbsel, in, 2, result select: 00 ALU, 01 load data, 10 PC+2, 11 reserved.
- mem_alu_result, in, 16, ALU result.
- mem_load_data, in, 16, data-memory read data.
- mem_pc_plus2, in, 16, link value.
- iss_valid, in, 1, decode is issuing an instruction this cycle.
- iss_regwrite, in, 1, the issuing instruction writes a register.
- iss_dst, in, 4, its destination register.
- can_valid, in, 1, a squashed in-flight writer is being cancelled.
- can_dst, in, 4, the cancelled writer's destination register.
- q_src1, in, 4, scoreboard query index 1.
- q_src2, in, 4, scoreboard query index 2.
- DstReg, out, 4, register-file write index.
- WriteReg, out, 1, register-file write enable.
- DstData, out, 16, register-file write data.
- q_busy1, out, 1, q_src1 has an uncommitted pending write.
- q_busy2, out, 1, q_src2 has an uncommitted pending write.
- sb_err, out, 1, sticky flag: scoreboard overflow or underflow.

Function
REQ-003 The unit SHALL hold the WB pipeline register: valid, regwrite, dst, wbsel and the three data operands; each posedge SHALL load the MEM inputs.
REQ-004 When stall=1, the WB register SHALL load a bubble (valid=0) instead of the MEM inputs.
REQ-005 Outputs SHALL be combinational from the WB register:
- DstReg = wb_dst.
- DstData = mux by wb_wbsel; 11 yields 16'h0000.
- WriteReg = wb_valid & wb_regwrite & (wb_dst != 0).
REQ-006 Register R0 SHALL never be written or counted; any issue, cancel or commit to index 0 SHALL be ignored.
REQ-007 Each register SHALL own a CNT_W-bit pending counter:
- +1 on iss_valid & iss_regwrite & match.
- -1 on commit (WriteReg=1) & match.
- -1 on can_valid & match.
REQ-008 Simultaneous events on the same register SHALL be summed (net range -2..+1) and applied in one cycle.
REQ-009 A counter at 3 with net +1 SHALL hold at 3 and set sb_err; a counter with a net decrement below 0 SHALL clamp at 0 and set sb_err.
REQ-010 q_busyN SHALL be 1 when counter[q_srcN] != 0, except 0 when that counter is 1, WriteReg=1 and DstReg=q_srcN (the register file bypasses same-cycle writes).
REQ-011 q_busyN SHALL be 0 when q_srcN = 0.
REQ-012 Latency: MEM inputs to a register-file write SHALL be exactly 1 cycle; a scoreboard update SHALL be visible on q_busy the next cycle.

Reset
REQ-013 While rst=1, at each posedge:
- WB register valid SHALL clear and the data operands SHALL clear to 0.
- All counters and sb_err SHALL clear.
REQ-014 While rst=1, WriteReg, q_busy1 and q_busy2 SHALL be 0 and DstReg/DstData SHALL be 0, with all inputs ignored.
REQ-015 A reset asserted mid-operation SHALL discard the in-flight WB write and all pending counts, with no partial commit.

Structure
REQ-016 A shared package SHALL hold the wbsel encodings (WB_ALU, WB_LOAD, WB_PC2), DATA_W, NREGS and CNT_W.
REQ-017 The pending counter SHALL be one sub-module, sb_counter (inc, dec-count 0..2, sat/err flag), instantiated NREGS-1 times.

Verification
REQ-018 Scenarios the bench SHALL cover:
- Issue dst=5, then MEM valid, wbsel=00, alu=16'h1234 -> next cycle WriteReg=1, DstReg=5, DstData=16'h1234; q_busy(5)=1 before commit, 0 during the commit cycle.
- MEM dst=0, regwrite=1 -> WriteReg=0; q_busy(0)=0 always.
- stall=1 with MEM valid -> WriteReg=0 the next cycle; counters unchanged.
- Issue r3 twice, then commit one r3 -> counter 1, q_busy(r3)=1; same-cycle issue r3 + commit r3 -> counter unchanged.
- Four issues to r7 with no commits -> counter saturates at 3, sb_err=1; cancel with counter at 0 -> stays 0, sb_err=1.
- rst=1 while WB valid, dst=9 -> no write; after reset all q_busy=0 and sb_err=0.
